// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, state and flag types for the sequential ALU
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLT = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
    } flags_t;

    // Width-independent flag derivation: callers pass only the sign bits,
    // the zero test of the final result and the raw carry/borrow/high-half bit.
    function automatic flags_t calc_flags(
        input op_t  op,
        input logic a_msb,
        input logic b_msb,
        input logic res_msb,
        input logic res_zero,
        input logic carry_ext
    );
        flags_t f;
        f.zero     = res_zero;
        f.negative = res_msb;
        f.carry    = 1'b0;
        f.overflow = 1'b0;
        case (op)
            OP_ADD: begin
                f.carry    = carry_ext;
                f.overflow = (a_msb == b_msb) && (res_msb != a_msb);
            end
            OP_SUB: begin
                f.carry    = carry_ext;
                f.overflow = (a_msb != b_msb) && (res_msb != a_msb);
            end
            OP_MUL:  f.carry = carry_ext;
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // done and product look ahead one step so the caller can latch the final
    // product on the same edge that performs the last iteration.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign done     = (cnt == CW'(1));
    assign product  = acc_next;

    // Load operands on start, then shift and accumulate until the count expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with handshakes, flags and iterative multiply
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             busy
);

    localparam logic [WIDTH-1:0] W_LIM = WIDTH[WIDTH-1:0];

    state_t             state;
    state_t             state_next;
    op_t                op_in;
    logic               ready_int;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cout;
    flags_t             alu_flags;
    flags_t             mul_flags;
    flags_t             flags_q;

    assign op_in     = op_t'(op);
    assign mul_start = accept && (op_in == OP_MUL);
    assign in_ready  = rst_n && ready_int;
    assign out_valid = (state == S_HOLD);
    assign busy      = (state == S_MUL);
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign negative  = flags_q.negative;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath evaluated on the live operands at the accept edge.
    always_comb begin
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} - {1'b0, b};
        alu_res  = '0;
        alu_cout = 1'b0;
        case (op_in)
            OP_ADD: begin
                alu_res  = sum_ext[WIDTH-1:0];
                alu_cout = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res  = diff_ext[WIDTH-1:0];
                alu_cout = diff_ext[WIDTH];
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  alu_res = (b < W_LIM) ? (a << b[SHW-1:0]) : '0;
            OP_SRL:  alu_res = (b < W_LIM) ? (a >> b[SHW-1:0]) : '0;
            default: ;
        endcase
        alu_flags = calc_flags(op_in, a[WIDTH-1], b[WIDTH-1], alu_res[WIDTH-1],
                               (alu_res == '0), alu_cout);
        mul_flags = calc_flags(OP_MUL, 1'b0, 1'b0, mul_product[WIDTH-1],
                               (mul_product[WIDTH-1:0] == '0),
                               (|mul_product[2*WIDTH-1:WIDTH]));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Handshake and next-state decode; HOLD can accept on the draining edge.
    always_comb begin
        state_next = state;
        ready_int  = 1'b0;
        case (state)
            S_IDLE:  ready_int = 1'b1;
            S_HOLD:  ready_int = out_ready;
            default: ready_int = 1'b0;
        endcase
        accept = in_valid && ready_int;
        case (state)
            S_IDLE: if (accept) state_next = (op_in == OP_MUL) ? S_MUL : S_HOLD;
            S_MUL:  if (mul_done) state_next = S_HOLD;
            S_HOLD: begin
                if (accept)         state_next = (op_in == OP_MUL) ? S_MUL : S_HOLD;
                else if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output registers: written on a single-cycle accept or on multiply completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            flags_q <= '0;
        end else if (accept && (op_in != OP_MUL)) begin
            result  <= alu_res;
            flags_q <= alu_flags;
        end else if ((state == S_MUL) && mul_done) begin
            result  <= mul_product[WIDTH-1:0];
            flags_q <= mul_flags;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with directed vectors
module tb_alu_seq;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] SLT = 3'b100, SLL = 3'b101, SRL = 3'b110, MUL = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [2:0] op = 3'b000;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       in_ready, out_valid, zero, carry, overflow, negative, busy;
    logic [7:0] result;

    typedef struct {
        logic [7:0] res;
        logic [3:0] fl;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Issue one operation; the expected response (flags as {z,c,v,n}) goes to the scoreboard.
    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] r, input logic [3:0] f, input string tag);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, 0, 1);
        e.res = r; e.fl = f; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~x;
        b = ~y;
    endtask

    // Count cycles from accept to out_valid, and busy cycles on the way.
    task automatic wait_out(input int lat, input int busy_cycles, input string tag);
        int n, nb, nr;
        n = 0; nb = 0; nr = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (busy && in_ready) nr++;
        end while (!out_valid && n < 40);
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_busy_cycles"}, nb, busy_cycles);
        if (busy_cycles > 0) chk({tag, "_in_ready_while_busy"}, nr, 0);
    endtask

    // Monitor: every output handshake pops and checks one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, "_result"}, result, e.res);
                    chk({e.tag, "_flags_zcvn"}, {zero, carry, overflow, negative}, e.fl);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        #2;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", {zero, carry, overflow, negative}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(ADD, 8'hF0, 8'h20, 8'h10, 4'b0100, "add_carry");    wait_out(1, 0, "add_carry");
        send(ADD, 8'h7F, 8'h01, 8'h80, 4'b0011, "add_ovf");      wait_out(1, 0, "add_ovf");
        send(SUB, 8'h05, 8'h05, 8'h00, 4'b1000, "sub_zero");     wait_out(1, 0, "sub_zero");
        send(SUB, 8'h80, 8'h01, 8'h7F, 4'b0010, "sub_ovf");      wait_out(1, 0, "sub_ovf");
        send(SUB, 8'h01, 8'h02, 8'hFF, 4'b0101, "sub_borrow");   wait_out(1, 0, "sub_borrow");
        send(MUL, 8'h0D, 8'h0B, 8'h8F, 4'b0001, "mul_13x11");    wait_out(9, 8, "mul_13x11");
        send(MUL, 8'h10, 8'h10, 8'h00, 4'b1100, "mul_hi");       wait_out(9, 8, "mul_hi");

        // Backpressure in HOLD, then same-edge drain and accept.
        @(posedge clk); #1; out_ready = 1'b0;
        send(ADD, 8'h11, 8'h22, 8'h33, 4'b0000, "bp_add");       wait_out(1, 0, "bp_add");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_result_stable", result, 8'h33);
            chk("bp_flags_stable", {zero, carry, overflow, negative}, 0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        send(AND_, 8'hF0, 8'h3C, 8'h30, 4'b0000, "b2b_and");     wait_out(1, 0, "b2b_and");

        send(SLL, 8'h81, 8'h01, 8'h02, 4'b0000, "sll_1");        wait_out(1, 0, "sll_1");
        send(SLL, 8'h81, 8'h09, 8'h00, 4'b1000, "sll_9");        wait_out(1, 0, "sll_9");
        send(SRL, 8'h80, 8'h07, 8'h01, 4'b0000, "srl_7");        wait_out(1, 0, "srl_7");
        send(SLT, 8'hFF, 8'h01, 8'h01, 4'b0000, "slt_true");     wait_out(1, 0, "slt_true");
        send(SLT, 8'h01, 8'hFF, 8'h00, 4'b1000, "slt_false");    wait_out(1, 0, "slt_false");
        send(OR_, 8'h0F, 8'hA0, 8'hAF, 4'b0001, "or_neg");       wait_out(1, 0, "or_neg");

        // Reset in the middle of a multiply aborts it.
        @(posedge clk); #1;
        send(MUL, 8'h0D, 8'h0B, 8'h8F, 4'b0001, "mul_abort");
        repeat (4) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_in_ready", in_ready, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("release_no_out_valid", nv, 0);
        send(ADD, 8'h03, 8'h04, 8'h07, 4'b0000, "post_reset_add"); wait_out(1, 0, "post_reset_add");

        nv = 0;
        while (sb.size() != 0 && nv < 20) begin
            @(negedge clk);
            nv++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 8-bit combinational ALU. It adds a WIDTH parameter, a 3-bit opcode (ADD, SUB, AND, OR, SLT, SLL, SRL, MUL), a full flag set and valid/ready handshakes on input and output. Single-cycle ops have 1-cycle latency; MUL runs an iterative shift-add over WIDTH cycles. It sits between the operand-select stage and write-back in the datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
SHW, $clog2(WIDTH), shift-amount field width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and opcode valid
in_ready  output  1  block can accept an operation this cycle
op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 SLL, 110 SRL, 111 MUL
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result and flags valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  registered result
zero  output  1  result == 0
carry  output  1  ADD carry-out / SUB borrow / MUL high-half nonzero
overflow  output  1  signed overflow (ADD/SUB only)
negative  output  1  result[WIDTH-1]
busy  output  1  MUL iteration in progress

Behaviour:
- One clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.
- Reset (rst_n low, effective immediately): state=IDLE; out_valid, result, zero, carry, overflow, negative and busy = 0; in_ready forced 0 while rst_n is low.
- FSM states: IDLE, MUL, HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). Accept = in_valid && in_ready. op, a and b are captured at the accept edge; later input changes are ignored.
- On accept with a non-MUL op: result and flags are computed and registered at that edge; next state is HOLD; out_valid is high the following cycle (latency 1).
- On accept with MUL: a, b, a zeroed 2*WIDTH accumulator and a counter (WIDTH) are loaded; state goes to MUL with busy=1. The block iterates one multiplier bit per cycle. After exactly WIDTH cycles in MUL, result and flags are written and state goes to HOLD. out_valid rises WIDTH+1 cycles after the accept edge.
- HOLD: out_valid=1; result and flags stay stable until handshake.
  - out_ready=1 and no new accept: go to IDLE, out_valid drops next cycle.
  - out_ready=1 with in_valid: back-to-back accept on the same edge. Next state is HOLD (non-MUL) or MUL.
- Arithmetic (all modulo 2^WIDTH):
  - ADD: carry = carry-out; overflow = operands share a sign and the result sign differs.
  - SUB: a-b; carry = borrow (a<b unsigned); overflow = operand signs differ and the result sign differs from a.
  - SLT: result = 1 if signed a<b, else 0.
  - SLL/SRL: logical shifts by b. If b >= WIDTH, result = 0.
  - MUL: result = low WIDTH bits of the unsigned product; carry = high WIDTH bits nonzero.
  - AND/OR/SLT/SLL/SRL: carry = 0.
  - All ops other than ADD/SUB: overflow = 0.
  - zero and negative are derived from the final result for every op.
- Reset during MUL or HOLD aborts the operation: no result is presented after release, and the block resumes in IDLE.
- Undefined op encodings are impossible (full 3-bit decode).

Decomposition:
- Shared package alu_pkg holds:
  - op_t enum (the 8 opcodes)
  - state_t enum (IDLE, MUL, HOLD)
  - flags struct {zero, carry, overflow, negative}
  - function calc_flags(op, a, b, res_ext)
- Natural sub-module: alu_mul_iter, the iterative shift-add multiplier with start/done, parametrised by WIDTH. The top holds the FSM, single-cycle datapath, output registers and handshake.

Test Plan:
- WIDTH=8, ADD a=0xF0 b=0x20 -> out_valid 1 cycle after accept, result=0x10, carry=1, overflow=0, zero=0. ADD 0x7F+0x01 -> 0x80, overflow=1, negative=1.
- SUB 0x05-0x05 -> result=0x00, zero=1, carry=0. SUB 0x80-0x01 -> 0x7F, overflow=1. SUB 0x01-0x02 -> 0xFF, carry=1.
- MUL 13*11 -> busy high 8 cycles, out_valid exactly 9 cycles after accept, result=0x8F, carry=0. MUL 0x10*0x10 -> result=0x00, zero=1, carry=1. in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 3 cycles in HOLD -> result and flags stable, in_ready=0. Then out_ready=1 with in_valid (AND 0xF0,0x3C) -> same-edge accept, next result 0x30 with out_valid continuous.
- SLL 0x81 by 1 -> 0x02. SLL by b=9 -> 0x00, zero=1. SRL 0x80 by 7 -> 0x01. SLT a=0xFF b=0x01 -> 0x01. SLT a=0x01 b=0xFF -> 0x00.
- Drop rst_n on MUL cycle 4 -> out_valid, busy and result are 0 immediately. After release: in_ready=1 on the first cycle, no spurious out_valid. A new ADD completes normally.
